display_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one set of seven-segment cathode lines between `N_DIGITS` common-anode digits. It contains its own slot prescaler, rotates a digit index, selects the matching nibble from a frame-latched display word, and drives the active-low anodes. A ghost-suppression blank gap at the start of every slot, per-digit enables and optional leading-zero blanking are included. The block sits between the lab datapath, which produces the BCD/hex word, and the board's anode/segment pins; `nibble_out` feeds the external segment decoder.

---
 rtl/display_scan_ctrl.sv | 103 ++++++++++
 tb/tb_display_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: seven-segment digit multiplexer.
// Rotates a digit slot, frame-latches the word, drives active-low anodes.
//
// Ports:
//   clk_in     system clock, rising edge
//   reset      synchronous active-low reset
//   enable     high runs the scan, low freezes it and blanks
//   digits_in  display word, nibble i is digit i
//   digit_en   per-digit visibility mask
//   lz_blank   leading-zero blanking enable
//   anode_n    active-low anodes, at most one low
//   digit_sel  index of the current slot
//   nibble_out nibble of the current slot from the frame latch
//   slot_tick  one-cycle pulse on the first cycle of each slot
module display_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic [N_DIGITS-1:0]         digit_en,
  input  logic                        lz_blank,
  output logic [N_DIGITS-1:0]         anode_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic [3:0]                  nibble_out,
  output logic                        slot_tick
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] frame;
  logic [N_DIGITS-1:0]   vis;

  logic                  latch;
  logic                  in_gap;
  logic                  zero_run;
  logic [4*N_DIGITS-1:0] frame_nx;
  logic [N_DIGITS-1:0]   vis_new;
  logic [N_DIGITS-1:0]   vis_nx;
  logic [3:0]            nib_nx;

  // Latch only on an enabled slot-0 start so a frozen scan keeps
  // showing the held word.
  assign latch    = enable && (cnt == '0) && (idx == '0);
  assign frame_nx = latch ? digits_in : frame;
  assign vis_nx   = latch ? vis_new : vis;
  assign in_gap   = 32'(cnt) < 32'(BLANK_CYCLES);
  assign nib_nx   = frame_nx[{idx, 2'b00} +: 4];

  // Walk from the top digit down; zero_run stays set while every
  // nibble from the top to i is zero.
  always_comb begin
    zero_run = 1'b1;
    vis_new  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (digits_in[4*i +: 4] == 4'h0);
      vis_new[i] = digit_en[i] & ~(lz_blank & (i != 0) & zero_run);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
      vis        <= '0;
      anode_n    <= '1;
      digit_sel  <= '0;
      nibble_out <= '0;
      slot_tick  <= 1'b0;
    end else begin
      frame      <= frame_nx;
      vis        <= vis_nx;
      digit_sel  <= idx;
      nibble_out <= nib_nx;
      if (enable) begin
        slot_tick <= (cnt == '0);
        // One register drives all anodes, so slot changes never overlap.
        anode_n   <= (!in_gap && vis_nx[idx]) ? ~(ONE << idx) : '1;
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        anode_n   <= '1;
        slot_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: bench for display_scan_ctrl.
// Vector table, corner sequences and a random run vs a frame model.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int SD  = 8;
  localparam int BC  = 2;
  localparam int FRM = ND * SD;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  anode_n;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble_out;
  logic        slot_tick;

  int tests = 0;
  int fails = 0;

  // model state: enabled cycles since reset, latched word and mask
  int          m_e = 0;
  logic [15:0] m_frame = '0;
  logic [3:0]  m_vis = '0;

  display_scan_ctrl #(
    .N_DIGITS(ND),
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .digits_in(digits_in),
    .digit_en(digit_en),
    .lz_blank(lz_blank),
    .anode_n(anode_n),
    .digit_sel(digit_sel),
    .nibble_out(nibble_out),
    .slot_tick(slot_tick)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] vis_of(
    logic [15:0] d, logic [3:0] de, logic lz);
    logic [3:0] v;
    for (int i = 0; i < ND; i++) begin
      bit lead;
      lead = (i != 0) && ((d >> (4 * i)) == 16'h0);
      v[i] = de[i] && !(lz && lead);
    end
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: predict, clock, compare every output.
  task automatic step();
    logic [3:0] ea;
    logic [1:0] es;
    logic [3:0] enib;
    logic       et;
    int pos;
    int slot;
    pos  = m_e % SD;
    slot = (m_e / SD) % ND;
    if (!reset) begin
      m_e = 0;
      m_frame = '0;
      m_vis = '0;
      ea = 4'hF;
      es = 2'd0;
      enib = 4'h0;
      et = 1'b0;
    end else if (enable) begin
      if (m_e % FRM == 0) begin
        m_frame = digits_in;
        m_vis = vis_of(digits_in, digit_en, lz_blank);
      end
      ea = (pos < BC || !m_vis[slot]) ? 4'hF : ~(4'b1 << slot);
      es = 2'(slot);
      enib = 4'(m_frame >> (4 * slot));
      et = (pos == 0);
      m_e++;
    end else begin
      ea = 4'hF;
      es = 2'(slot);
      enib = 4'(m_frame >> (4 * slot));
      et = 1'b0;
    end
    @(posedge clk_in);
    #1;
    tests++;
    if (anode_n !== ea || digit_sel !== es ||
        nibble_out !== enib || slot_tick !== et) begin
      fails++;
      $display("FAIL model t=%0t anode_n %b/%b sel %0d/%0d nib %h/%h tick %b/%b",
               $time, anode_n, ea, digit_sel, es,
               nibble_out, enib, slot_tick, et);
    end
    tests++;
    if ($countones(~anode_n) > 1) begin
      fails++;
      $display("FAIL onehot: anode_n got %b required at most one low",
               anode_n);
    end
  endtask

  task automatic do_reset(logic [15:0] d);
    reset = 1'b0;
    enable = 1'b1;
    digits_in = d;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  de;
    logic        lz;
    logic [3:0]  lit;
    logic [15:0] nibs;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lowc[4];
    int ticks;
    int n;
    logic [15:0] obs;

    reset = 1'b0;
    enable = 1'b0;
    digits_in = '0;
    digit_en = '0;
    lz_blank = 1'b0;

    vt[0] = '{16'h1234, 4'hF, 1'b0, 4'b1111, 16'h1234};
    vt[1] = '{16'h0050, 4'hF, 1'b1, 4'b0011, 16'h0050};
    vt[2] = '{16'h0050, 4'hF, 1'b0, 4'b1111, 16'h0050};
    vt[3] = '{16'h0000, 4'hF, 1'b1, 4'b0001, 16'h0000};
    vt[4] = '{16'h1234, 4'h5, 1'b0, 4'b0101, 16'h1234};
    vt[5] = '{16'h0400, 4'hF, 1'b1, 4'b0111, 16'h0400};

    step();
    chk("reset anode_n", int'(anode_n), 4'hF);
    chk("reset digit_sel", int'(digit_sel), 0);
    chk("reset nibble_out", int'(nibble_out), 0);
    chk("reset slot_tick", int'(slot_tick), 0);

    foreach (vt[k]) begin
      do_reset(vt[k].d);
      digit_en = vt[k].de;
      lz_blank = vt[k].lz;
      for (int i = 0; i < ND; i++) lowc[i] = 0;
      ticks = 0;
      obs = '0;
      repeat (FRM) begin
        step();
        if (slot_tick) begin
          ticks++;
          obs[int'(digit_sel)*4 +: 4] = nibble_out;
        end
        for (int i = 0; i < ND; i++)
          if (!anode_n[i]) lowc[i]++;
      end
      chk($sformatf("vec%0d ticks", k), ticks, ND);
      for (int i = 0; i < ND; i++)
        chk($sformatf("vec%0d low%0d", k, i), lowc[i],
            vt[k].lit[i] ? SD - BC : 0);
      chk($sformatf("vec%0d nibbles", k), int'(obs), int'(vt[k].nibs));
      step();
      chk($sformatf("vec%0d period tick", k), int'(slot_tick), 1);
      chk($sformatf("vec%0d period sel", k), int'(digit_sel), 0);
    end

    // frame coherence: word changes mid slot 2
    do_reset(16'h1234);
    obs = '0;
    for (int c = 0; c < FRM; c++) begin
      if (c == 19) digits_in = 16'hABCD;
      step();
      if (slot_tick) obs[int'(digit_sel)*4 +: 4] = nibble_out;
    end
    chk("coherent frame", int'(obs), 16'h1234);
    step();
    chk("new frame nib", int'(nibble_out), 4'hD);
    chk("new frame sel", int'(digit_sel), 0);

    // enable freeze mid slot 1
    do_reset(16'h1234);
    lowc[1] = 0;
    repeat (SD + 3) begin
      step();
      if (!anode_n[1]) lowc[1]++;
    end
    enable = 1'b0;
    repeat (5) begin
      step();
      chk("freeze anode_n", int'(anode_n), 4'hF);
      chk("freeze tick", int'(slot_tick), 0);
    end
    enable = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (slot_tick) break;
      if (!anode_n[1]) lowc[1]++;
    end
    chk("resume cycles to tick", n, 6);
    chk("resume next sel", int'(digit_sel), 2);
    chk("slot1 low total", lowc[1], SD - BC);

    // reset during slot 3
    do_reset(16'h1234);
    repeat (26) step();
    reset = 1'b0;
    digits_in = 16'h9876;
    step();
    chk("midrst anode_n", int'(anode_n), 4'hF);
    chk("midrst sel", int'(digit_sel), 0);
    chk("midrst nib", int'(nibble_out), 0);
    chk("midrst tick", int'(slot_tick), 0);
    reset = 1'b1;
    step();
    chk("rel tick", int'(slot_tick), 1);
    chk("rel sel", int'(digit_sel), 0);
    chk("rel nib", int'(nibble_out), 4'h6);

    // random run
    for (int c = 0; c < 10000; c++) begin
      logic [31:0] r;
      int sh;
      r = $urandom;
      sh = $urandom_range(1, 4);
      reset = ($urandom_range(0, 499) != 0);
      enable = ($urandom_range(0, 9) != 0);
      digits_in = 16'(r) & 16'((32'h1 << (4 * sh)) - 1);
      digit_en = 4'($urandom);
      lz_blank = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
